// File: rtl/amplitude_ramp_pwm.sv
// Multi-channel log-volume stage: slews 4-bit levels, gates by tone bit, log-maps to PWM/DAC drive.
// Latency: control->level 1 cycle, level/in->amp/dac 1 cycle; no handshake, never stalls.
module amplitude_ramp_pwm #(
   parameter int CHANNELS    = 3,
   parameter int VOLUME_BITS = 10,
   parameter int RAMP_DIV    = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CHANNELS-1:0]             in,
   input  logic [4*CHANNELS-1:0]           control,
   input  logic                            ramp_en,
   output logic [4*CHANNELS-1:0]           level_out,
   output logic [VOLUME_BITS*CHANNELS-1:0] amp_out,
   output logic [CHANNELS-1:0]             pwm_out,
   output logic                            mix_pwm_out,
   output logic [15*CHANNELS-1:0]          dac_out
);

   localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
   localparam int SUM_BITS = VOLUME_BITS + CH_BITS;
   localparam int PRE_BITS = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(RAMP_DIV - 1);
   localparam logic [63:0] MAX_VAL = (64'd1 << VOLUME_BITS) - 64'd1;

   // Table fractions are in thousandths; trunc(MAX*f) with a floor of 1 for any non-zero level.
   function automatic logic [VOLUME_BITS-1:0] log_amp(input logic [3:0] lvl);
      logic [9:0]  milli;
      logic [63:0] prod;
      case (lvl)
         4'd15:   milli = 10'd1000;
         4'd14:   milli = 10'd707;
         4'd13:   milli = 10'd500;
         4'd12:   milli = 10'd354;
         4'd11:   milli = 10'd250;
         4'd10:   milli = 10'd177;
         4'd9:    milli = 10'd125;
         4'd8:    milli = 10'd89;
         4'd7:    milli = 10'd63;
         4'd6:    milli = 10'd45;
         4'd5:    milli = 10'd32;
         4'd4:    milli = 10'd23;
         4'd3:    milli = 10'd16;
         4'd2:    milli = 10'd12;
         4'd1:    milli = 10'd8;
         default: milli = 10'd0;
      endcase
      prod = (MAX_VAL * {54'd0, milli}) / 64'd1000;
      if (lvl == 4'd0)
         return '0;
      else if (prod == 64'd0)
         return VOLUME_BITS'(1);
      else
         return prod[VOLUME_BITS-1:0];
   endfunction

   logic [PRE_BITS-1:0]             pre_cnt;
   logic                            step;
   logic [SUM_BITS-1:0]             pwm_cnt;
   logic [SUM_BITS-1:0]             amp_sum;
   logic [3:0]                      gated [CHANNELS];
   logic [VOLUME_BITS*CHANNELS-1:0] amp_nxt;
   logic [15*CHANNELS-1:0]          dac_nxt;
   logic [CHANNELS-1:0]             pwm_nxt;

   assign step = ramp_en && (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pre_cnt <= '0;
      else if (!ramp_en || step)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   // Target is re-read on every strobe, so a moving target redirects the slew immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_out <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!ramp_en)
               level_out[4*i +: 4] <= control[4*i +: 4];
            else if (step) begin
               if (level_out[4*i +: 4] < control[4*i +: 4])
                  level_out[4*i +: 4] <= level_out[4*i +: 4] + 4'd1;
               else if (level_out[4*i +: 4] > control[4*i +: 4])
                  level_out[4*i +: 4] <= level_out[4*i +: 4] - 4'd1;
            end
         end
      end
   end

   // Gate after the ramp so tone toggling reaches the output unslewed.
   always_comb begin
      amp_nxt = '0;
      dac_nxt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         gated[i] = in[i] ? level_out[4*i +: 4] : 4'd0;
         amp_nxt[VOLUME_BITS*i +: VOLUME_BITS] = log_amp(gated[i]);
         if (gated[i] != 4'd0)
            dac_nxt[15*i +: 15] = 15'd1 << (gated[i] - 4'd1);
      end
   end

   always_comb begin
      amp_sum = '0;
      pwm_nxt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         amp_sum    = amp_sum + SUM_BITS'(amp_out[VOLUME_BITS*i +: VOLUME_BITS]);
         pwm_nxt[i] = pwm_cnt[VOLUME_BITS-1:0] < amp_out[VOLUME_BITS*i +: VOLUME_BITS];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt     <= '0;
         amp_out     <= '0;
         dac_out     <= '0;
         pwm_out     <= '0;
         mix_pwm_out <= 1'b0;
      end else begin
         pwm_cnt     <= pwm_cnt + 1'b1;
         amp_out     <= amp_nxt;
         dac_out     <= dac_nxt;
         pwm_out     <= pwm_nxt;
         mix_pwm_out <= pwm_cnt < amp_sum;
      end
   end

endmodule
